// File: rtl/div2_bit_serializer_if.sv
// Bit-stream handshake between the divide-by-2 serializer and its consumer.
interface div2_bit_serializer_if;
  logic bit_out;
  logic bit_valid;
  logic bit_last;
  logic bit_ready;

  modport master (output bit_out, output bit_valid, output bit_last, input bit_ready);
  modport slave  (input bit_out, input bit_valid, input bit_last, output bit_ready);
endinterface

// File: rtl/div2_bit_serializer.sv
// LSB-first serializer: emits q mod 2 and shifts q right (q div 2)
// until the remaining quotient is zero. An operand of zero emits a single 0 bit.
module div2_bit_serializer (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   a,
  div2_bit_serializer_if.master        bits,
  output logic                         busy,
  output logic                         done,
  output logic [3:0]                   count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] q, q_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       out_bit, out_valid, out_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      q     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs decode only state and q, so bit_ready/start never reach an output combinationally.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    cnt_nxt   = cnt;
    out_bit   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          q_nxt     = a;
          cnt_nxt   = '0;
          state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_bit   = q[0];
        out_last  = (q[7:1] == 7'd0);
        if (bits.bit_ready) begin
          q_nxt   = {1'b0, q[7:1]};
          cnt_nxt = cnt + 4'd1;
          if (out_last) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bits.bit_out   = out_bit;
  assign bits.bit_valid = out_valid;
  assign bits.bit_last  = out_last;
  assign count          = cnt;

endmodule

// File: tb/tb_div2_bit_serializer.sv
// Directed bench for div2_bit_serializer: table of operands plus
// backpressure, start-while-busy and mid-stream reset sequences.
module tb_div2_bit_serializer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic       busy;
  logic       done;
  logic [3:0] count;

  div2_bit_serializer_if bits ();

  div2_bit_serializer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .bits  (bits),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] av;
    int         len;
    int         inject;  // bit index at which a stray start with a=0xFF is pulsed, -1 for none
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_bit_out"},   32'(bits.bit_out),   32'd0);
    check({tag, "_bit_valid"}, 32'(bits.bit_valid), 32'd0);
    check({tag, "_bit_last"},  32'(bits.bit_last),  32'd0);
    check({tag, "_busy"},      32'(busy),           32'd0);
    check({tag, "_done"},      32'(done),           32'd0);
    check({tag, "_count"},     32'(count),          32'd0);
  endtask

  // Called at a negedge while the DUT idles; returns at the negedge after the post-done IDLE cycle.
  task automatic run_stream(input logic [7:0] av, input int len, input int inject);
    start = 1'b1;
    a     = av;
    bits.bit_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~av;
    for (int i = 0; i < len; i++) begin
      check("stream_valid", 32'(bits.bit_valid), 32'd1);
      check("stream_bit",   32'(bits.bit_out),   32'(av[i]));
      check("stream_last",  32'(bits.bit_last),  32'(i == len - 1));
      check("stream_busy",  32'(busy),           32'd1);
      check("stream_done",  32'(done),           32'd0);
      check("stream_count", 32'(count),          32'(i));
      if (i == inject) begin
        start = 1'b1;
        a     = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_pulse", 32'(done),           32'd1);
    check("done_valid", 32'(bits.bit_valid), 32'd0);
    check("done_busy",  32'(busy),           32'd1);
    check("done_count", 32'(count),          32'(len));
    @(negedge clk);
    check("idle_done",  32'(done),           32'd0);
    check("idle_busy",  32'(busy),           32'd0);
    check("idle_valid", 32'(bits.bit_valid), 32'd0);
    check("idle_count", 32'(count),          32'(len));
  endtask

  initial begin
    logic [7:0] bp_av;
    logic       pat[7];
    int         idx;
    int         c;

    vecs[0] = '{av: 8'hB5, len: 8, inject: 3};
    vecs[1] = '{av: 8'hFF, len: 8, inject: -1};
    vecs[2] = '{av: 8'h06, len: 3, inject: -1};
    vecs[3] = '{av: 8'h01, len: 1, inject: -1};
    vecs[4] = '{av: 8'h00, len: 1, inject: -1};
    vecs[5] = '{av: 8'h40, len: 7, inject: 0};

    reset = 1'b0;
    start = 1'b0;
    a     = '0;
    bits.bit_ready = 1'b0;
    #3;
    check_idle_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_zero("post_reset");

    for (int v = 0; v < 6; v++)
      run_stream(vecs[v].av, vecs[v].len, vecs[v].inject);

    // Backpressure on 0x80: outputs must hold on every ready=0 cycle.
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bp_av = 8'h80;
    start = 1'b1;
    a     = bp_av;
    @(negedge clk);
    start = 1'b0;
    idx   = 0;
    c     = 0;
    while (idx < 8 && c < 40) begin
      check("bp_valid", 32'(bits.bit_valid), 32'd1);
      check("bp_bit",   32'(bits.bit_out),   32'(bp_av[idx]));
      check("bp_last",  32'(bits.bit_last),  32'(idx == 7));
      check("bp_count", 32'(count),          32'(idx));
      bits.bit_ready = pat[c % 7];
      if (pat[c % 7]) idx++;
      c++;
      @(negedge clk);
    end
    check("bp_timeout", 32'(c < 40), 32'd1);
    check("bp_done",    32'(done),   32'd1);
    check("bp_count_f", 32'(count),  32'd8);
    bits.bit_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_busy", 32'(busy), 32'd0);

    // Reset asserted between edges after three bits of 0xB5.
    start = 1'b1;
    a     = 8'hB5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_count", 32'(count), 32'd3);
    check("mid_bit",   32'(bits.bit_out), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check_idle_zero("async_reset");
    @(negedge clk);
    check_idle_zero("held_reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_zero("after_release");
    run_stream(8'h03, 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
